// File: rtl/regfile_pkg.sv
// Shared constants and writeback record types for the regfile write-port arbiter.
// The struct field widths follow the package constants below.
package regfile_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int ADDR_WIDTH = 5;
   localparam int ZERO_REG   = 31;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } wb_req_t;

   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } wb_out_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: a single request always wins; on a tie the
// requester that did not win last time is granted.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last_grant;

   always_comb begin
      // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
      gnt = 2'b00;
      if (!reset) begin
         if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
         else              gnt = req;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset)     last_grant <= 1'b1;
      else if (|gnt) last_grant <= gnt[1];
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU and load writeback, with a
// registered write stage, forwarding for the in-flight write and a conflict counter.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
   parameter int ZERO_REG   = regfile_pkg::ZERO_REG
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_data,
   output logic                  req1_ready,
   output logic                  RegWrite,
   output logic [ADDR_WIDTH-1:0] WriteRegister,
   output logic [DATA_WIDTH-1:0] WriteData,
   input  logic [ADDR_WIDTH-1:0] ReadRegister1,
   input  logic [ADDR_WIDTH-1:0] ReadRegister2,
   output logic                  fwd1_valid,
   output logic [DATA_WIDTH-1:0] fwd1_data,
   output logic                  fwd2_valid,
   output logic [DATA_WIDTH-1:0] fwd2_data,
   output logic [15:0]           conflict_count
);

   logic [1:0] gnt;
   wb_req_t    sel;
   wb_out_t    out_q;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   ({req1_valid, req0_valid}),
      .gnt   (gnt)
   );

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];

   always_comb begin
      sel = '{addr: req0_addr, data: req0_data};
      if (gnt[1]) sel = '{addr: req1_addr, data: req1_data};
   end

   // Zero-register grants still complete the handshake but never raise the write enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q <= '0;
      end else if (|gnt) begin
         out_q.we   <= (sel.addr != ADDR_WIDTH'(ZERO_REG));
         out_q.addr <= sel.addr;
         out_q.data <= sel.data;
      end else begin
         out_q.we <= 1'b0;
      end
   end

   assign RegWrite      = out_q.we;
   assign WriteRegister = out_q.addr;
   assign WriteData     = out_q.data;

   assign fwd1_valid = out_q.we && (ReadRegister1 == out_q.addr);
   assign fwd2_valid = out_q.we && (ReadRegister2 == out_q.addr);
   assign fwd1_data  = fwd1_valid ? out_q.data : '0;
   assign fwd2_data  = fwd2_valid ? out_q.data : '0;

   always_ff @(posedge clk) begin
      if (reset)
         conflict_count <= '0;
      else if (req0_valid && req1_valid && (conflict_count != 16'hFFFF))
         conflict_count <= conflict_count + 16'd1;
   end

endmodule
